// File: rtl/shift_sub_divider.sv
// ---------------------------------------------------------------------------
// shift_sub_divider
//
// Unsigned restoring (shift/subtract) divider. It produces one quotient bit
// per clock, so a SIZE-bit division takes SIZE cycles in RUN plus one DONE
// cycle.
//
// Optional feature (compile-time macro):
//   DIV_BY_ZERO_DETECT_EN
//     Defined: a zero divisor at Start skips RUN. The block goes straight to
//     DONE with Quotient = all ones, Remainder = Data_A and Div_By_Zero = 1.
//     Undefined: a zero divisor runs the normal sequence. The algorithm then
//     produces the same Quotient and Remainder, and Div_By_Zero stays 0.
//
// Ports:
//   Clock       in   rising-edge clock
//   Reset       in   synchronous active-high reset
//   Start       in   begin a division (sampled only in IDLE)
//   Data_A      in   SIZE-bit dividend, unsigned
//   Data_B      in   SIZE-bit divisor, unsigned
//   Quotient    out  registered quotient, held until the next result
//   Remainder   out  registered remainder, held until the next result
//   Busy        out  high while iterating (RUN)
//   Done        out  one-cycle pulse when a result becomes valid
//   Div_By_Zero out  zero-divisor flag, held until the next Start
// ---------------------------------------------------------------------------
module shift_sub_divider #(
    parameter int SIZE = 32
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Start,
    input  logic [SIZE-1:0] Data_A,
    input  logic [SIZE-1:0] Data_B,
    output logic [SIZE-1:0] Quotient,
    output logic [SIZE-1:0] Remainder,
    output logic            Busy,
    output logic            Done,
    output logic            Div_By_Zero
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    // shift_reg starts as the dividend. Quotient bits enter at the LSB while
    // dividend bits leave at the MSB.
    logic [SIZE-1:0] shift_reg;
    logic [SIZE-1:0] divisor_reg;
    // The partial remainder is always below the divisor, so its top bit is
    // always zero. Only the low SIZE bits are stored. The shifted value and
    // the compare use the full SIZE+1 bits.
    logic [SIZE-1:0] rem_reg;
    logic [CW-1:0]   count_reg;
    logic [SIZE-1:0] quotient_reg;
    logic [SIZE-1:0] remainder_reg;
    logic            dbz_reg;

    logic [SIZE:0]   rem_shift;
    logic [SIZE-1:0] rem_diff;
    logic            q_bit;
    logic [SIZE-1:0] rem_step;
    logic [SIZE-1:0] shift_step;
    logic            zero_div;

`ifdef DIV_BY_ZERO_DETECT_EN
    assign zero_div = (Data_B == '0);
`else
    assign zero_div = 1'b0;
`endif

    // One restoring step. When q_bit is set, the true difference is below
    // the divisor, so the low SIZE bits of the subtraction are exact.
    always_comb begin
        rem_shift  = {rem_reg, shift_reg[SIZE-1]};
        q_bit      = (rem_shift >= {1'b0, divisor_reg});
        rem_diff   = rem_shift[SIZE-1:0] - divisor_reg;
        rem_step   = q_bit ? rem_diff : rem_shift[SIZE-1:0];
        shift_step = {shift_reg[SIZE-2:0], q_bit};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    state_next = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                // count_reg == 1 means the final iteration happens at this edge.
                if (count_reg == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            divisor_reg   <= '0;
            rem_reg       <= '0;
            count_reg     <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        shift_reg   <= Data_A;
                        divisor_reg <= Data_B;
                        rem_reg     <= '0;
                        count_reg   <= CW'(SIZE);
                        dbz_reg     <= zero_div;
                        if (zero_div) begin
                            quotient_reg  <= '1;
                            remainder_reg <= Data_A;
                        end
                    end
                end
                RUN: begin
                    shift_reg <= shift_step;
                    rem_reg   <= rem_step;
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        quotient_reg  <= shift_step;
                        remainder_reg <= rem_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Quotient    = quotient_reg;
    assign Remainder   = remainder_reg;
    assign Busy        = (state_reg == RUN);
    assign Done        = (state_reg == DONE);
    assign Div_By_Zero = dbz_reg;

endmodule

// File: tb/tb_shift_sub_divider.sv
// ---------------------------------------------------------------------------
// tb_shift_sub_divider
//
// Self-checking bench for shift_sub_divider (SIZE = 32). Expected results are
// pushed to a queue when a Start is driven. A monitor pops them when Done
// pulses. Scenario tasks check latency, Busy, hold, reset and throughput.
// ---------------------------------------------------------------------------
module tb_shift_sub_divider;

    localparam int SIZE = 32;
`ifdef DIV_BY_ZERO_DETECT_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    logic            Clock = 1'b0;
    logic            Reset;
    logic            Start;
    logic [SIZE-1:0] Data_A;
    logic [SIZE-1:0] Data_B;
    logic [SIZE-1:0] Quotient;
    logic [SIZE-1:0] Remainder;
    logic            Busy;
    logic            Done;
    logic            Div_By_Zero;

    shift_sub_divider #(.SIZE(SIZE)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Data_A      (Data_A),
        .Data_B      (Data_B),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Busy        (Busy),
        .Done        (Done),
        .Div_By_Zero (Div_By_Zero)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [SIZE-1:0] q;
        logic [SIZE-1:0] r;
        logic            dbz;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    longint cycle = 0;

    always @(posedge Clock) cycle <= cycle + 1;

    // Scoreboard monitor: every Done must match the oldest pending division.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (Done === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done: Done=1 at cycle %0d, required no pending result", cycle);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (Quotient !== e.q) begin
                        n_bad++;
                        $display("FAIL quotient %0d/%0d: got %0d, expected %0d", e.a, e.b, Quotient, e.q);
                    end
                    n_cmp++;
                    if (Remainder !== e.r) begin
                        n_bad++;
                        $display("FAIL remainder %0d/%0d: got %0d, expected %0d", e.a, e.b, Remainder, e.r);
                    end
                    n_cmp++;
                    if (Div_By_Zero !== e.dbz) begin
                        n_bad++;
                        $display("FAIL div_by_zero %0d/%0d: got %b, expected %b", e.a, e.b, Div_By_Zero, e.dbz);
                    end
                    $display("result %0d / %0d -> q=%0d r=%0d dbz=%b at cycle %0d",
                             e.a, e.b, Quotient, Remainder, Div_By_Zero, cycle);
                end
            end
        end
    end

    // Drive a one-cycle Start. On return we are at the negedge that follows
    // the sampling edge t.
    task automatic do_start(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input bit accept);
        exp_t e;
        @(negedge Clock);
        Data_A = a;
        Data_B = b;
        Start  = 1'b1;
        if (accept) begin
            e.a = a;
            e.b = b;
            if (b == '0) begin
                e.q   = '1;
                e.r   = a;
                e.dbz = DZ;
            end else begin
                e.q   = a / b;
                e.r   = a % b;
                e.dbz = 1'b0;
            end
            sb.push_back(e);
        end
        @(negedge Clock);
        Start = 1'b0;
    endtask

    // Wait (bounded) for Done. Report the negedges elapsed and the Busy samples seen.
    task automatic wait_done(output int n, output int busy_cnt);
        n        = 0;
        busy_cnt = 0;
        while (Done !== 1'b1 && n < 100) begin
            if (Busy === 1'b1) busy_cnt++;
            @(negedge Clock);
            n++;
        end
    endtask

    function automatic int exp_lat(input logic [SIZE-1:0] b);
        return (DZ && b == '0) ? 0 : SIZE;
    endfunction

    task automatic test_reset();
        Reset  = 1'b1;
        Start  = 1'b0;
        Data_A = '0;
        Data_B = '0;
        repeat (3) @(negedge Clock);
        n_cmp++;
        if ({Quotient, Remainder, Busy, Done, Div_By_Zero} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: q=%h r=%h busy=%b done=%b dbz=%b, expected all 0",
                     Quotient, Remainder, Busy, Done, Div_By_Zero);
        end
        // Reset together with Start: reset wins, so no division begins.
        Data_A = 32'd5;
        Data_B = 32'd1;
        Start  = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        @(negedge Clock);
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_over_start: busy=%b done=%b, expected 0 0", Busy, Done);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int n, bc;
        do_start(32'd100, 32'd7, 1'b1);
        wait_done(n, bc);
        n_cmp++;
        if (n != SIZE) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d cycles, expected %0d", n, SIZE);
        end
        n_cmp++;
        if (bc != SIZE) begin
            n_bad++;
            $display("FAIL basic_busy_cycles: got %0d, expected %0d", bc, SIZE);
        end
        n_cmp++;
        if (Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_busy_in_done: got %b, expected 0", Busy);
        end
        @(negedge Clock);
        n_cmp++;
        if (Done !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_done_pulse: Done still %b one cycle later, expected 0", Done);
        end
        repeat (3) @(negedge Clock);
        n_cmp++;
        if (Quotient !== 32'd14 || Remainder !== 32'd2) begin
            n_bad++;
            $display("FAIL basic_hold: q=%0d r=%0d, expected 14 2", Quotient, Remainder);
        end
        $display("test_basic done");
    endtask

    task automatic test_back_to_back();
        int n, bc;
        longint t1, t2;
        do_start(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_done(n, bc);
        t1 = cycle;
        do_start(32'd5, 32'd10, 1'b1);
        wait_done(n, bc);
        t2 = cycle;
        n_cmp++;
        if (t2 - t1 != SIZE + 2) begin
            n_bad++;
            $display("FAIL b2b_spacing: got %0d cycles between Done pulses, expected %0d", t2 - t1, SIZE + 2);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_div_zero();
        int n, bc;
        do_start(32'h1234_5678, 32'd0, 1'b1);
        wait_done(n, bc);
        n_cmp++;
        if (n != exp_lat(32'd0)) begin
            n_bad++;
            $display("FAIL dz_latency: got %0d cycles, expected %0d", n, exp_lat(32'd0));
        end
        n_cmp++;
        if (bc != exp_lat(32'd0)) begin
            n_bad++;
            $display("FAIL dz_busy_cycles: got %0d, expected %0d", bc, exp_lat(32'd0));
        end
        repeat (3) @(negedge Clock);
        n_cmp++;
        if (Div_By_Zero !== DZ) begin
            n_bad++;
            $display("FAIL dz_flag_hold: got %b, expected %b", Div_By_Zero, DZ);
        end
        $display("test_div_zero done");
    endtask

    task automatic test_ignore_start();
        int n, bc;
        bit extra;
        do_start(32'd1000, 32'd3, 1'b1);
        repeat (9) @(negedge Clock);
        Data_A = 32'd9;
        Data_B = 32'd9;
        Start  = 1'b1;
        @(negedge Clock);
        Start  = 1'b0;
        wait_done(n, bc);
        n_cmp++;
        if (n != SIZE - 10) begin
            n_bad++;
            $display("FAIL ignore_latency: got %0d cycles after restart, expected %0d", n, SIZE - 10);
        end
        extra = 1'b0;
        repeat (40) begin
            @(negedge Clock);
            if (Done === 1'b1 || Busy === 1'b1) extra = 1'b1;
        end
        n_cmp++;
        if (extra !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_no_second_run: activity seen=%b, expected 0", extra);
        end
        $display("test_ignore_start done");
    endtask

    task automatic test_reset_abort();
        int n, bc;
        bit extra;
        do_start(32'd1000, 32'd3, 1'b1);
        repeat (15) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        void'(sb.pop_front());
        n_cmp++;
        if ({Quotient, Remainder, Busy, Done, Div_By_Zero} !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: q=%0d r=%0d busy=%b done=%b dbz=%b, expected all 0",
                     Quotient, Remainder, Busy, Done, Div_By_Zero);
        end
        extra = 1'b0;
        repeat (40) begin
            @(negedge Clock);
            if (Done === 1'b1 || Busy === 1'b1) extra = 1'b1;
        end
        n_cmp++;
        if (extra !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done: activity seen=%b, expected 0", extra);
        end
        do_start(32'd50, 32'd8, 1'b1);
        wait_done(n, bc);
        n_cmp++;
        if (n != SIZE) begin
            n_bad++;
            $display("FAIL abort_restart_latency: got %0d, expected %0d", n, SIZE);
        end
        $display("test_reset_abort done");
    endtask

    task automatic test_random();
        int n, bc;
        logic [SIZE-1:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? SIZE'($urandom_range(1, 1000)) : SIZE'($urandom >> (i * 3));
            if (b == '0) b = 32'd1;
            do_start(a, b, 1'b1);
            wait_done(n, bc);
            n_cmp++;
            if (n != SIZE) begin
                n_bad++;
                $display("FAIL random_latency %0d: got %0d, expected %0d", i, n, SIZE);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_random();
        repeat (5) @(negedge Clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_sub_divider.md
SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 Parameter: SIZE, default 32, operand/result width in bits; the block SHALL support 32.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 Data_A  input  SIZE  dividend, unsigned.
REQ-006 Data_B  input  SIZE  divisor, unsigned.
REQ-007 Quotient  output  SIZE  registered quotient.
REQ-008 Remainder  output  SIZE  registered remainder.
REQ-009 Busy  output  1  high while the division is in progress (RUN state).
REQ-010 Done  output  1  single-cycle pulse; Quotient and Remainder are valid from this cycle on.
REQ-011 Div_By_Zero  output  1  divisor-zero flag, valid while Done is high and held until the next Start.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE, with transitions IDLE->RUN on Start=1, RUN->DONE after SIZE iterations, and DONE->IDLE unconditionally after one cycle.
REQ-013 In IDLE with Start=1, the block SHALL do the following at that edge: latch Data_A into the dividend/quotient shift register, latch Data_B into the divisor register, clear the (SIZE+1)-bit partial remainder, and load the iteration counter with SIZE.
REQ-014 In RUN, each edge SHALL perform one restoring step.
  - R' = {R[SIZE-1:0], dividend MSB}; the dividend register shifts left by 1.
  - If R' >= divisor: R = R' - divisor and the inserted quotient LSB = 1.
  - Otherwise: R = R' and the inserted quotient LSB = 0.
  - The counter decrements by 1.
REQ-015 Operands SHALL be unsigned, the comparison SHALL use SIZE+1 bits, and no overflow SHALL be possible.
REQ-016 Latency: with Start sampled at edge t, the last iteration SHALL occur at edge t+SIZE and Quotient/Remainder SHALL update at that edge.
REQ-017 Done SHALL be high only during the cycle between edges t+SIZE and t+SIZE+1.
REQ-018 Busy SHALL be high from edge t+1 through edge t+SIZE, and low in IDLE and DONE.
REQ-019 Start SHALL be ignored in RUN and DONE; no queuing, and operand changes during RUN SHALL have no effect.
REQ-020 Quotient and Remainder SHALL hold their values until the next completed division or until Reset.
REQ-021 A Start in the cycle immediately after Done SHALL be accepted, giving back-to-back throughput of one result per SIZE+2 cycles.

Reset
REQ-022 Reset=1 at a rising edge SHALL force IDLE and clear the counter, the partial remainder and all outputs: Quotient=0, Remainder=0, Busy=0, Done=0, Div_By_Zero=0.
REQ-023 Reset SHALL take priority over Start and over an in-progress RUN; an aborted division SHALL produce no Done.

Configuration
REQ-024 The macro DIV_BY_ZERO_DETECT_EN SHALL control divide-by-zero detection.
REQ-025 With DIV_BY_ZERO_DETECT_EN defined and Data_B=0 at Start, the block SHALL do the following:
  - go IDLE->DONE directly, setting Quotient={SIZE{1'b1}}, Remainder=Data_A and Div_By_Zero=1 at edge t.
  - assert Done during the cycle t to t+1, with Busy never asserted.
REQ-026 With DIV_BY_ZERO_DETECT_EN undefined, a zero divisor SHALL run the normal SIZE-cycle sequence and produce Quotient={SIZE{1'b1}} and Remainder=Data_A by the algorithm, with Div_By_Zero tied to 0.
REQ-027 A nonzero divisor SHALL behave identically in both builds.

Verification
REQ-028 Data_A=100, Data_B=7, Start pulsed at edge t -> Busy for 32 cycles, Done at cycle t+32 to t+33, Quotient=14, Remainder=2, Div_By_Zero=0.
REQ-029 Data_A=32'hFFFFFFFF, Data_B=1, followed by back-to-back Start with Data_A=5, Data_B=10 -> first Quotient=32'hFFFFFFFF and Remainder=0; second Quotient=0 and Remainder=5; second Done exactly 34 cycles after the first.
REQ-030 Data_A=32'h12345678, Data_B=0 -> with DIV_BY_ZERO_DETECT_EN: Done one cycle after Start, Quotient=32'hFFFFFFFF, Remainder=32'h12345678, Div_By_Zero=1; without it: Done after 32 cycles, same Quotient/Remainder, Div_By_Zero=0.
REQ-031 Start Data_A=1000, Data_B=3, then pulse Start with Data_A=9, Data_B=9 at iteration 10 -> second Start ignored; Quotient=333, Remainder=1.
REQ-032 Start Data_A=1000, Data_B=3, assert Reset at iteration 16 -> next cycle all outputs 0, no Done; a new Start with Data_A=50, Data_B=8 -> Quotient=6, Remainder=2.
